vnu_ser: RTL

VNU_SER -- requirements
Module: vnu_ser

---
 rtl/vnu_ser.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vnu_ser.sv
// Serial LDPC variable-node unit: accumulates DV check messages onto the
// channel LLR, then streams extrinsic variable-to-check messages back out.
module vnu_ser #(
  parameter int DV    = 3,
  parameter int idx_w = 3,
  parameter int res_w = 6,
  parameter int ext_w = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic signed [res_w-1:0]      lch,
  input  logic                         r_valid,
  output logic                         r_ready,
  input  logic signed [res_w-1:0]      r,
  output logic                         q_valid,
  input  logic                         q_ready,
  output logic signed [res_w+ext_w-1:0] q,
  output logic [idx_w-1:0]             q_idx,
  output logic                         dec,
  output logic                         dec_valid,
  output logic                         busy
);

  localparam int data_w = res_w + ext_w;
  localparam int acc_w  = data_w + 2;
  // The running sum of lch plus up to 2^idx_w messages needs
  // res_w+idx_w+1 bits, and the extrinsic difference one more; widen the
  // accumulator beyond acc_w when the extension bits are too few so no
  // intermediate value can wrap.
  localparam int min_w  = res_w + idx_w + 2;
  localparam int sum_w  = (acc_w > min_w) ? acc_w : min_w;
  localparam int depth  = 2 ** idx_w;

  localparam logic [idx_w-1:0] last = idx_w'(DV - 1);
  localparam logic [idx_w-1:0] one  = idx_w'(1);

  localparam logic signed [sum_w-1:0] q_max =
    sum_w'(2 ** (data_w - 1) - 1);
  localparam logic signed [sum_w-1:0] q_min = -q_max;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    EMIT
  } state_t;

  state_t                    state;
  logic signed [sum_w-1:0]   acc;
  logic [idx_w-1:0]          cnt;
  logic signed [res_w-1:0]   msg_buf [depth];

  logic signed [sum_w-1:0]   acc_nx;
  logic signed [sum_w-1:0]   diff_first;
  logic signed [sum_w-1:0]   diff_next;
  logic [idx_w-1:0]          nidx;

  function automatic logic signed [sum_w-1:0] sx(
    input logic signed [res_w-1:0] v
  );
    return sum_w'(v);
  endfunction

  // Symmetric clamp: the most negative code is never emitted.
  function automatic logic signed [data_w-1:0] sat(
    input logic signed [sum_w-1:0] d
  );
    logic signed [sum_w-1:0] c;
    c = d;
    if (d > q_max)
      c = q_max;
    else if (d < q_min)
      c = q_min;
    return data_w'(c);
  endfunction

  // Next-accumulator and next-extrinsic datapath.
  always_comb begin
    acc_nx     = acc + sx(r);
    diff_first = acc_nx - sx(msg_buf[0]);
    nidx       = cnt + one;
    diff_next  = acc - sx(msg_buf[nidx]);
  end

  assign r_ready = en && (state == ACC);
  assign q_valid = (state == EMIT);
  assign busy    = (state != IDLE);

  // Node FSM: accumulate, then emit one extrinsic per edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      q         <= '0;
      q_idx     <= '0;
      dec       <= 1'b0;
      dec_valid <= 1'b0;
      for (int i = 0; i < depth; i++)
        msg_buf[i] <= '0;
    end else if (en) begin
      dec_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= sx(lch);
            cnt   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (r_valid) begin
            msg_buf[cnt] <= r;
            acc          <= acc_nx;
            if (cnt == last) begin
              cnt       <= '0;
              dec       <= acc_nx[sum_w-1];
              dec_valid <= 1'b1;
              q         <= sat(diff_first);
              q_idx     <= '0;
              state     <= EMIT;
            end else begin
              cnt <= nidx;
            end
          end
        end
        EMIT: begin
          if (q_ready) begin
            if (cnt == last) begin
              cnt   <= '0;
              q     <= '0;
              q_idx <= '0;
              state <= IDLE;
            end else begin
              cnt   <= nidx;
              q     <= sat(diff_next);
              q_idx <= nidx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
